// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer feeding the SISO stage.
// Optional even-parity bit per frame: define PISO_PARITY_EN.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    GAP    = 2'd2,
    PARITY = 2'd3
  } state_t;

  localparam int SISO_WIDTH = 4;
  localparam int GAP_W      = 4;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int SISO_CNT_W = cnt_width(SISO_WIDTH);

endpackage

// File: rtl/piso_gap_counter.sv
// Loadable down-counter with zero flag; times the inter-frame gap.
// Holds at zero rather than wrapping.
module piso_gap_counter
  import piso_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [GAP_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - GAP_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out feeder for the SISO stage, valid/ready input side.
// Optional even-parity bit after each word: define PISO_PARITY_EN.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = SISO_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             fill_req,
  output logic             serial_out,
  output logic             shift_en,
  output logic             fill_ones,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE  = CW'(WIDTH - 2);
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // Word is reordered at capture so emission is always LSB-first.
  function automatic logic [WIDTH-1:0] order(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = MSB_FIRST ? w[WIDTH-1-i] : w[i];
    end
    return r;
  endfunction

  state_t           state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             ser_q, ser_d;
  logic             sen_q, sen_d;
  logic             fill_q, fill_d;
  logic             done_q, done_d;
  logic             gap_load, gap_dec, gap_zero;
  logic             finish, accept;
  logic [WIDTH-1:0] ord;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  assign ord = order(in_data);

  always_comb begin
    state_d  = state;
    sreg_d   = sreg;
    cnt_d    = cnt;
    ser_d    = 1'b0;
    sen_d    = 1'b0;
    fill_d   = 1'b0;
    done_d   = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    finish   = 1'b0;
    accept   = 1'b0;
    in_ready = 1'b0;
`ifdef PISO_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state)
      IDLE: begin
        in_ready = ~fill_req;
        fill_d   = fill_req;
        accept   = in_valid & ~fill_req;
      end
      SHIFT: begin
        if (cnt != LAST) begin
          ser_d  = sreg[0];
          sreg_d = sreg >> 1;
          sen_d  = 1'b1;
          cnt_d  = cnt + CW'(1);
          done_d = ~PAR_EN && (cnt == PRE);
        end else begin
`ifdef PISO_PARITY_EN
          ser_d   = par_q;
          sen_d   = 1'b1;
          done_d  = 1'b1;
          state_d = PARITY;
`else
          finish  = 1'b1;
`endif
        end
      end
      PARITY: finish = 1'b1;
      GAP: begin
        gap_dec = 1'b1;
        if (gap_zero) state_d = IDLE;
      end
    endcase
    // Last bit on the line: either open a gap or take the next word now.
    if (finish) begin
      if (GAP_CYCLES > 0) begin
        state_d  = GAP;
        gap_load = 1'b1;
      end else begin
        state_d  = IDLE;
        in_ready = 1'b1;
        accept   = in_valid;
      end
    end
    if (accept) begin
      ser_d   = ord[0];
      sreg_d  = ord >> 1;
      sen_d   = 1'b1;
      cnt_d   = '0;
      done_d  = 1'b0;
      state_d = SHIFT;
`ifdef PISO_PARITY_EN
      par_d   = ^in_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      ser_q  <= 1'b0;
      sen_q  <= 1'b0;
      fill_q <= 1'b0;
      done_q <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      sreg   <= sreg_d;
      cnt    <= cnt_d;
      ser_q  <= ser_d;
      sen_q  <= sen_d;
      fill_q <= fill_d;
      done_q <= done_d;
`ifdef PISO_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

  piso_gap_counter u_gap (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  assign serial_out = ser_q;
  assign shift_en   = sen_q;
  assign fill_ones  = fill_q;
  assign frame_done = done_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: cycle table plus streamed frames.
// Three instances cover MSB/LSB-first and gap / no-gap streaming.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int   FL = 4 + P;
  localparam logic NP = (P == 0);
  localparam logic PB = (P != 0);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in_data [3];
  logic       in_valid [3];
  logic       fill_req [3];
  logic       rdy [3];
  logic       ser [3];
  logic       sen [3];
  logic       fo [3];
  logic       fd [3];
  logic       busy [3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(1)) u_a (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(rdy[0]), .fill_req(fill_req[0]), .serial_out(ser[0]),
    .shift_en(sen[0]), .fill_ones(fo[0]), .frame_done(fd[0]), .busy(busy[0]));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP_CYCLES(1)) u_b (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(rdy[1]), .fill_req(fill_req[1]), .serial_out(ser[1]),
    .shift_en(sen[1]), .fill_ones(fo[1]), .frame_done(fd[1]), .busy(busy[1]));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_c (
    .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(rdy[2]), .fill_req(fill_req[2]), .serial_out(ser[2]),
    .shift_en(sen[2]), .fill_ones(fo[2]), .frame_done(fd[2]), .busy(busy[2]));

  // Downstream 4-bit SISO model fed by instance a.
  logic [3:0] siso;
  always @(posedge clk) begin
    if (reset) siso <= 4'h0;
    else if (fo[0]) siso <= 4'hF;
    else if (sen[0]) siso <= {siso[2:0], ser[0]};
  end

  typedef struct {
    logic v; logic [3:0] d; logic f;
    logic s, e, fo, fd, r, b;
    logic cs; logic [3:0] sv;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [3:0] d, input logic f,
                     input logic s, input logic e, input logic o,
                     input logic dn, input logic r, input logic b,
                     input logic cs, input logic [3:0] sv);
    vec_t x;
    x.v = v; x.d = d; x.f = f; x.s = s; x.e = e; x.fo = o;
    x.fd = dn; x.r = r; x.b = b; x.cs = cs; x.sv = sv;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Feed nw words to instance d holding valid; collect the serial stream.
  task automatic stream(input int d, input int nw, input logic [3:0] w0,
                        input logic [3:0] w1, output logic [31:0] val,
                        output int nb, output int nd, output int dat,
                        output bit cont, output bit ok);
    int sent, first, lastk;
    bit acc;
    val = '0; nb = 0; nd = 0; dat = 0; sent = 0;
    first = -1; lastk = -1; ok = 1'b0;
    in_data[d] = w0;
    in_valid[d] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sen[d]) begin
        val = {val[30:0], ser[d]};
        nb++;
        if (first < 0) first = k;
        lastk = k;
      end
      if (fd[d]) begin
        nd++;
        dat = nb;
      end
      if (nb > 0 && !sen[d] && sent == nw) begin
        ok = 1'b1;
        break;
      end
      acc = in_valid[d] & rdy[d];
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        if (sent < nw) in_data[d] = w1;
        else in_valid[d] = 1'b0;
      end
    end
    in_valid[d] = 1'b0;
    cont = (lastk - first + 1 == nb);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] val;
    int nb, nd, dat;
    bit cont, ok;

    for (int i = 0; i < 3; i++) begin
      in_data[i] = 4'h0;
      in_valid[i] = 1'b0;
      fill_req[i] = 1'b0;
    end

    add(1, 4'b1011, 0, 0, 0, 0, 0, 1, 0, 0, 4'h0);
    add(0, 4'b0000, 0, 1, 1, 0, 0, 0, 1, 0, 4'h0);
    add(0, 4'b0000, 0, 0, 1, 0, 0, 0, 1, 0, 4'h0);
    add(0, 4'b0000, 0, 1, 1, 0, 0, 0, 1, 0, 4'h0);
    add(0, 4'b0000, 0, 1, 1, 0, NP, 0, 1, 0, 4'h0);
    if (P != 0) add(0, 4'b0000, 0, 1, 1, 0, 1, 0, 1, 0, 4'h0);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0);
    add(1, 4'b0110, 1, 0, 0, 0, 0, 0, 0, 1, PB ? 4'b0111 : 4'b1011);
    add(1, 4'b0110, 0, 0, 0, 1, 0, 1, 0, 0, 4'h0);
    add(0, 4'b0000, 1, 0, 1, 0, 0, 0, 1, 1, 4'hF);
    add(0, 4'b0000, 0, 1, 1, 0, 0, 0, 1, 0, 4'h0);
    add(0, 4'b0000, 0, 1, 1, 0, 0, 0, 1, 0, 4'h0);
    add(0, 4'b0000, 0, 0, 1, 0, NP, 0, 1, 0, 4'h0);
    if (P != 0) add(0, 4'b0000, 0, 0, 1, 0, 1, 0, 1, 0, 4'h0);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 1, PB ? 4'b1100 : 4'b0110);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset shift_en", 32'(sen[0]), 0);
    chk("reset serial", 32'(ser[0]), 0);
    chk("reset busy", 32'(busy[0]), 0);
    chk("reset in_ready", 32'(rdy[0]), 1);
    chk("reset fill_ones", 32'(fo[0]), 0);
    chk("reset frame_done", 32'(fd[0]), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      in_valid[0] = tbl[i].v;
      in_data[0]  = tbl[i].d;
      fill_req[0] = tbl[i].f;
      @(negedge clk);
      chk($sformatf("row%0d serial", i), 32'(ser[0]), 32'(tbl[i].s));
      chk($sformatf("row%0d shift_en", i), 32'(sen[0]), 32'(tbl[i].e));
      chk($sformatf("row%0d fill_ones", i), 32'(fo[0]), 32'(tbl[i].fo));
      chk($sformatf("row%0d frame_done", i), 32'(fd[0]), 32'(tbl[i].fd));
      chk($sformatf("row%0d in_ready", i), 32'(rdy[0]), 32'(tbl[i].r));
      chk($sformatf("row%0d busy", i), 32'(busy[0]), 32'(tbl[i].b));
      if (tbl[i].cs)
        chk($sformatf("row%0d siso", i), 32'(siso), 32'(tbl[i].sv));
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    fill_req[0] = 1'b0;

    stream(2, 2, 4'b1100, 4'b0011, val, nb, nd, dat, cont, ok);
    chk("b2b finished", 32'(ok), 1);
    chk("b2b bits", val, PB ? 32'h306 : 32'hC3);
    chk("b2b count", 32'(nb), 32'(2 * FL));
    chk("b2b contiguous", 32'(cont), 1);
    chk("b2b done pulses", 32'(nd), 2);
    chk("b2b last done", 32'(dat), 32'(2 * FL));

    stream(1, 1, 4'b0001, 4'b0000, val, nb, nd, dat, cont, ok);
    chk("lsb finished", 32'(ok), 1);
    chk("lsb bits", val, PB ? 32'h11 : 32'h8);
    chk("lsb count", 32'(nb), 32'(FL));
    chk("lsb done pulses", 32'(nd), 1);
    chk("lsb done pos", 32'(dat), 32'(FL));

    in_data[0] = 4'hF;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("pre-reset serial", 32'(ser[0]), 1);
    chk("pre-reset shift_en", 32'(sen[0]), 1);
    chk("pre-reset frame_done", 32'(fd[0]), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid reset shift_en", 32'(sen[0]), 0);
    chk("mid reset busy", 32'(busy[0]), 0);
    chk("mid reset in_ready", 32'(rdy[0]), 1);
    chk("mid reset serial", 32'(ser[0]), 0);
    chk("mid reset frame_done", 32'(fd[0]), 0);
    @(posedge clk);
    #1;

    stream(0, 1, 4'b1011, 4'b0000, val, nb, nd, dat, cont, ok);
    chk("recover finished", 32'(ok), 1);
    chk("recover bits", val, PB ? 32'h17 : 32'hB);
    chk("recover count", 32'(nb), 32'(FL));
    chk("recover done pos", 32'(dat), 32'(FL));

    stream(0, 1, 4'b0111, 4'b0000, val, nb, nd, dat, cont, ok);
    chk("frame finished", 32'(ok), 1);
    chk("frame bits", val, PB ? 32'hF : 32'h7);
    chk("frame count", 32'(nb), 32'(FL));
    chk("frame done pulses", 32'(nd), 1);
    chk("frame done pos", 32'(dat), 32'(FL));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
